// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, one-hot status encodings,
// the "no register" specifier and the nop image loaded into pipeline registers.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] S_AOK = 4'b1000;
    localparam logic [3:0] S_HLT = 4'b0100;
    localparam logic [3:0] S_ADR = 4'b0010;
    localparam logic [3:0] S_INS = 4'b0001;

    localparam logic [3:0] RNONE = 4'hF;

    typedef struct packed {
        logic [3:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
    } d_reg_t;

    localparam logic [3:0]  NOP_STAT  = S_AOK;
    localparam logic [3:0]  NOP_ICODE = I_NOP;
    localparam logic [3:0]  NOP_IFUN  = 4'h0;
    localparam logic [63:0] NOP_VALC  = 64'h0;
    localparam logic [63:0] NOP_VALP  = 64'h0;

    localparam d_reg_t D_NOP = '{stat: NOP_STAT, icode: NOP_ICODE, ifun: NOP_IFUN,
                                 ra: RNONE, rb: RNONE, valc: NOP_VALC, valp: NOP_VALP};

    function automatic logic need_regids_f(input logic [3:0] icode);
        case (icode)
            I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
            I_OPQ, I_PUSHQ, I_POPQ: need_regids_f = 1'b1;
            default:                need_regids_f = 1'b0;
        endcase
    endfunction

    function automatic logic need_valc_f(input logic [3:0] icode);
        case (icode)
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_JXX, I_CALL: need_valc_f = 1'b1;
            default:                                     need_valc_f = 1'b0;
        endcase
    endfunction

    function automatic logic instr_valid_f(input logic [3:0] icode);
        instr_valid_f = (icode <= I_POPQ);
    endfunction

endpackage

// File: rtl/fetch_split.sv
// Combinational instruction splitter: decodes the fetched byte window into
// icode/ifun, register specifiers, constant word, validity and next sequential PC.
module fetch_split
    import y86_pkg::*;
(
    input  logic [63:0] f_pc,
    input  logic [79:0] imem_bytes,
    input  logic        imem_error,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic        instr_valid
);

    logic [3:0]  icode_s;
    logic [3:0]  ifun_s;
    logic        need_regids_s;
    logic        need_valc_s;
    logic [3:0]  ra_s;
    logic [3:0]  rb_s;
    logic [63:0] valc_s;
    logic [63:0] valp_s;

    // Byte split, register/constant extraction and sequential successor.
    always_comb begin
        icode_s       = I_NOP;
        ifun_s        = 4'h0;
        ra_s          = RNONE;
        rb_s          = RNONE;
        valc_s        = 64'h0;
        // A bad fetch address is carried down the pipe as a nop tagged ADR.
        if (imem_error) begin
            icode_s = I_NOP;
            ifun_s  = 4'h0;
        end else begin
            icode_s = imem_bytes[7:4];
            ifun_s  = imem_bytes[3:0];
        end
        need_regids_s = need_regids_f(icode_s);
        need_valc_s   = need_valc_f(icode_s);
        if (need_regids_s) begin
            ra_s = imem_bytes[15:12];
            rb_s = imem_bytes[11:8];
        end else begin
            ra_s = RNONE;
            rb_s = RNONE;
        end
        // The constant word shifts up one byte when a register byte precedes it.
        if (!need_valc_s) begin
            valc_s = 64'h0;
        end else if (need_regids_s) begin
            valc_s = imem_bytes[79:16];
        end else begin
            valc_s = imem_bytes[71:8];
        end
        valp_s = f_pc + 64'd1 + {63'd0, need_regids_s} + {60'd0, need_valc_s, 3'b000};
    end

    assign icode       = icode_s;
    assign ifun        = ifun_s;
    assign rA          = ra_s;
    assign rB          = rb_s;
    assign valC        = valc_s;
    assign valP        = valp_s;
    assign instr_valid = instr_valid_f(icode_s);

endmodule

// File: rtl/pipe_fetch.sv
// Y86-64 fetch stage: PC select, predicted-PC (F) register, status/prediction
// logic and the F/D pipeline register driven by stall/bubble control.
module pipe_fetch
    import y86_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        F_stall,
    input  logic        D_stall,
    input  logic        D_bubble,
    input  logic [3:0]  M_icode,
    input  logic        M_Cnd,
    input  logic [63:0] M_valA,
    input  logic [3:0]  W_icode,
    input  logic [63:0] W_valM,
    output logic [63:0] imem_addr,
    input  logic [79:0] imem_bytes,
    input  logic        imem_error,
    output logic [3:0]  D_stat,
    output logic [3:0]  D_icode,
    output logic [3:0]  D_ifun,
    output logic [3:0]  D_rA,
    output logic [3:0]  D_rB,
    output logic [63:0] D_valC,
    output logic [63:0] D_valP,
    output logic [63:0] f_predPC
);

    logic [63:0] f_pred_pc_r;
    d_reg_t      d_r;

    logic [63:0] f_pc_s;
    logic [3:0]  f_icode_s;
    logic [3:0]  f_ifun_s;
    logic [3:0]  f_ra_s;
    logic [3:0]  f_rb_s;
    logic [63:0] f_valc_s;
    logic [63:0] f_valp_s;
    logic        f_valid_s;
    logic [3:0]  f_stat_s;
    logic [63:0] f_pred_next_s;
    d_reg_t      f_fields_s;

    // Fetch PC select: a mispredicted branch outranks a returning ret.
    always_comb begin
        f_pc_s = f_pred_pc_r;
        if ((M_icode == I_JXX) && !M_Cnd) begin
            f_pc_s = M_valA;
        end else if (W_icode == I_RET) begin
            f_pc_s = W_valM;
        end else begin
            f_pc_s = f_pred_pc_r;
        end
    end

    fetch_split u_fetch_split (
        .f_pc        (f_pc_s),
        .imem_bytes  (imem_bytes),
        .imem_error  (imem_error),
        .icode       (f_icode_s),
        .ifun        (f_ifun_s),
        .rA          (f_ra_s),
        .rB          (f_rb_s),
        .valC        (f_valc_s),
        .valP        (f_valp_s),
        .instr_valid (f_valid_s)
    );

    // Status priority and next-PC prediction (jumps and calls taken, ret falls through).
    always_comb begin
        f_stat_s      = S_AOK;
        f_pred_next_s = f_valp_s;
        if (imem_error) begin
            f_stat_s = S_ADR;
        end else if (!f_valid_s) begin
            f_stat_s = S_INS;
        end else if (f_icode_s == I_HALT) begin
            f_stat_s = S_HLT;
        end else begin
            f_stat_s = S_AOK;
        end
        if ((f_icode_s == I_JXX) || (f_icode_s == I_CALL)) begin
            f_pred_next_s = f_valc_s;
        end else begin
            f_pred_next_s = f_valp_s;
        end
    end

    assign f_fields_s = '{stat: f_stat_s, icode: f_icode_s, ifun: f_ifun_s,
                          ra: f_ra_s, rb: f_rb_s, valc: f_valc_s, valp: f_valp_s};

    // F register: predicted PC, held while fetch is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            f_pred_pc_r <= RESET_PC;
        end else if (F_stall) begin
            f_pred_pc_r <= f_pred_pc_r;
        end else begin
            f_pred_pc_r <= f_pred_next_s;
        end
    end

    // D register: stall beats bubble so a held instruction is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_r <= D_NOP;
        end else if (D_stall) begin
            d_r <= d_r;
        end else if (D_bubble) begin
            d_r <= D_NOP;
        end else begin
            d_r <= f_fields_s;
        end
    end

    assign imem_addr = f_pc_s;
    assign f_predPC  = f_pred_next_s;
    assign D_stat    = d_r.stat;
    assign D_icode   = d_r.icode;
    assign D_ifun    = d_r.ifun;
    assign D_rA      = d_r.ra;
    assign D_rB      = d_r.rb;
    assign D_valC    = d_r.valc;
    assign D_valP    = d_r.valp;

endmodule

// File: tb/tb_pipe_fetch.sv
// Self-checking bench for pipe_fetch: a reference fetch model predicts the PC and
// D register each cycle; expected D contents are queued and compared after the edge.
module tb_pipe_fetch;

    typedef struct packed {
        logic [3:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
    } dexp_t;

    localparam logic [63:0] RST_PC = 64'h0;
    localparam dexp_t EXP_NOP = '{stat: 4'b1000, icode: 4'h1, ifun: 4'h0, ra: 4'hF,
                                  rb: 4'hF, valc: 64'h0, valp: 64'h0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        F_stall = 1'b0;
    logic        D_stall = 1'b0;
    logic        D_bubble = 1'b0;
    logic [3:0]  M_icode = 4'h0;
    logic        M_Cnd = 1'b0;
    logic [63:0] M_valA = 64'h0;
    logic [3:0]  W_icode = 4'h0;
    logic [63:0] W_valM = 64'h0;
    logic [63:0] imem_addr;
    logic [79:0] imem_bytes = 80'h0;
    logic        imem_error = 1'b0;
    logic [3:0]  D_stat, D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC, D_valP, f_predPC;

    int    n_cmp = 0;
    int    n_bad = 0;
    dexp_t exp_q[$];
    dexp_t m_d;
    logic [63:0] m_pred;

    pipe_fetch #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
        .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valA(M_valA), .W_icode(W_icode), .W_valM(W_valM),
        .imem_addr(imem_addr), .imem_bytes(imem_bytes), .imem_error(imem_error),
        .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
        .D_valC(D_valC), .D_valP(D_valP), .f_predPC(f_predPC)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_pc();
        if (M_icode == 4'h7 && M_Cnd == 1'b0) return M_valA;
        if (W_icode == 4'h9) return W_valM;
        return m_pred;
    endfunction

    function automatic void model_fetch(input logic [63:0] pc, input logic [79:0] b,
                                        input logic err, output dexp_t d,
                                        output logic [63:0] pred);
        logic regs, cw;
        d.icode = err ? 4'h1 : b[7:4];
        d.ifun  = err ? 4'h0 : b[3:0];
        regs = d.icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
        cw   = d.icode inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
        d.ra   = regs ? b[15:12] : 4'hF;
        d.rb   = regs ? b[11:8]  : 4'hF;
        d.valc = !cw ? 64'h0 : (regs ? b[79:16] : b[71:8]);
        d.valp = pc + 64'd1 + (regs ? 64'd1 : 64'd0) + (cw ? 64'd8 : 64'd0);
        if (err)                 d.stat = 4'b0010;
        else if (d.icode > 4'hB) d.stat = 4'b0001;
        else if (d.icode == 4'h0) d.stat = 4'b0100;
        else                     d.stat = 4'b1000;
        pred = (d.icode == 4'h7 || d.icode == 4'h8) ? d.valc : d.valp;
    endfunction

    task automatic compare_d();
        dexp_t e;
        if (exp_q.size() == 0) begin
            check("queue_empty", 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check("D_stat", {60'd0, D_stat}, {60'd0, e.stat});
            check("D_icode", {60'd0, D_icode}, {60'd0, e.icode});
            check("D_ifun", {60'd0, D_ifun}, {60'd0, e.ifun});
            check("D_rA", {60'd0, D_rA}, {60'd0, e.ra});
            check("D_rB", {60'd0, D_rB}, {60'd0, e.rb});
            check("D_valC", D_valC, e.valc);
            check("D_valP", D_valP, e.valp);
        end
    endtask

    // One clock: drive bytes, check combinational outputs, queue expected D, compare after edge.
    task automatic step(input logic [79:0] bytes, input logic err);
        dexp_t dec;
        logic [63:0] pc_e, pred_e;
        imem_bytes = bytes;
        imem_error = err;
        #1;
        if (rst) begin
            m_pred = RST_PC;
            m_d    = EXP_NOP;
        end else begin
            pc_e = model_pc();
            model_fetch(pc_e, bytes, err, dec, pred_e);
            check("imem_addr", imem_addr, pc_e);
            check("f_predPC", f_predPC, pred_e);
            if (!F_stall) m_pred = pred_e;
            if (D_stall)       m_d = m_d;
            else if (D_bubble) m_d = EXP_NOP;
            else               m_d = dec;
        end
        exp_q.push_back(m_d);
        @(posedge clk);
        #1;
        compare_d();
    endtask

    task automatic idle();
        rst = 1'b0; F_stall = 1'b0; D_stall = 1'b0; D_bubble = 1'b0;
        M_icode = 4'h0; M_Cnd = 1'b0; M_valA = 64'h0; W_icode = 4'h0; W_valM = 64'h0;
    endtask

    logic [63:0] saved_addr;
    logic [3:0]  saved_icode;
    logic [63:0] saved_valp;

    initial begin
        @(negedge clk);
        rst = 1'b1;
        step(80'h0, 1'b0);
        idle();
        #1;
        check("reset_addr", imem_addr, RST_PC);

        // irmovq $10, %rdx at PC 0
        step({64'd10, 8'hF2, 8'h30}, 1'b0);
        check("irmov_icode", {60'd0, D_icode}, 64'd3);
        check("irmov_rB", {60'd0, D_rB}, 64'd2);
        check("irmov_valC", D_valC, 64'd10);
        check("irmov_valP", D_valP, 64'd10);
        check("irmov_stat", {60'd0, D_stat}, 64'h8);

        // ret redirect to 0x40
        W_icode = 4'h9; W_valM = 64'h40;
        #1;
        check("ret_redirect", imem_addr, 64'h40);
        step({72'h0, 8'h10}, 1'b0);
        // ret redirect to 0x20 where a jmp 0x100 sits
        W_valM = 64'h20;
        step({8'h00, 64'h100, 8'h70}, 1'b0);
        check("jxx_valC", D_valC, 64'h100);
        idle();
        #1;
        check("jxx_pred_addr", imem_addr, 64'h100);
        // mispredict and ret together: M_valA wins
        M_icode = 4'h7; M_Cnd = 1'b0; M_valA = 64'h29; W_icode = 4'h9; W_valM = 64'h40;
        #1;
        check("mispredict_wins", imem_addr, 64'h29);
        step({72'h0, 8'h10}, 1'b0);
        // taken branch in M is not a redirect
        M_icode = 4'h7; M_Cnd = 1'b1; M_valA = 64'h77; W_icode = 4'h0;
        step({16'h0, 64'h1234, 8'h03, 8'h62}, 1'b0);

        // stall both F and D for two cycles
        idle();
        F_stall = 1'b1; D_stall = 1'b1;
        #1;
        saved_addr = imem_addr; saved_icode = D_icode; saved_valp = D_valP;
        for (int i = 0; i < 2; i++) begin
            step({16'h0, 64'hDEAD, 8'h45, 8'h40}, 1'b0);
            check("stall_addr", imem_addr, saved_addr);
            check("stall_icode", {60'd0, D_icode}, {60'd0, saved_icode});
            check("stall_valP", D_valP, saved_valp);
        end
        // bubble alone, then bubble with stall
        idle();
        D_bubble = 1'b1;
        step({16'h0, 64'h55, 8'h45, 8'h40}, 1'b0);
        check("bubble_icode", {60'd0, D_icode}, 64'd1);
        check("bubble_rA", {60'd0, D_rA}, 64'hF);
        check("bubble_stat", {60'd0, D_stat}, 64'h8);
        idle();
        step({16'h0, 64'h66, 8'h45, 8'h40}, 1'b0);
        D_stall = 1'b1; D_bubble = 1'b1;
        step({72'h0, 8'h00}, 1'b0);
        check("stall_beats_bubble", {60'd0, D_icode}, 64'd4);

        // status cases
        idle();
        step({72'h0, 8'h30}, 1'b1);
        check("adr_stat", {60'd0, D_stat}, 64'h2);
        check("adr_icode", {60'd0, D_icode}, 64'd1);
        step({72'h0, 8'hC0}, 1'b0);
        check("ins_stat", {60'd0, D_stat}, 64'h1);
        W_icode = 4'h9; W_valM = 64'h300;
        step({72'hFF, 8'h00}, 1'b0);
        check("hlt_stat", {60'd0, D_stat}, 64'h4);
        check("hlt_valP", D_valP, 64'h301);

        // valP wrap with a 10-byte mrmovq
        W_valM = 64'hFFFF_FFFF_FFFF_FFF8;
        step({64'h18, 8'h01, 8'h50}, 1'b0);
        check("wrap_valP", D_valP, 64'h2);

        // reset while stalled and bubbling
        idle();
        F_stall = 1'b1; D_stall = 1'b1; D_bubble = 1'b1; rst = 1'b1;
        step({72'h0, 8'h60}, 1'b0);
        idle();
        #1;
        check("midstall_reset_addr", imem_addr, RST_PC);

        // random traffic
        for (int i = 0; i < 60; i++) begin
            F_stall  = ($urandom_range(0, 4) == 0);
            D_stall  = ($urandom_range(0, 4) == 0);
            D_bubble = ($urandom_range(0, 4) == 0);
            M_icode  = ($urandom_range(0, 3) == 0) ? 4'h7 : 4'($urandom_range(0, 15));
            M_Cnd    = 1'($urandom_range(0, 1));
            M_valA   = {32'h0, $urandom};
            W_icode  = ($urandom_range(0, 5) == 0) ? 4'h9 : 4'h0;
            W_valM   = {$urandom, $urandom};
            step({16'($urandom), $urandom, $urandom}, ($urandom_range(0, 7) == 0));
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
